// File: rtl/multicycle_adder.sv
// ---------------------------------------------------------------------------
// multicycle_adder
//
// Adds (or subtracts) two WIDTH-bit operands CHUNK bits per clock, LSB chunk
// first, carrying between chunks in a single stored carry bit. A result
// takes N = WIDTH/CHUNK cycles after the accept edge and is then held
// until the consumer takes it.
//
// Parameters
//   WIDTH     operand / result width in bits
//   CHUNK     bits added per cycle (WIDTH % CHUNK == 0, CHUNK >= 1)
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  operands and mode present
//   in_ready  block can accept an operation (IDLE only)
//   a, b      operands
//   cin       carry-in, add mode only
//   sub       0: a + b + cin, 1: a - b (cin ignored)
//   out_valid result present (DONE only)
//   out_ready consumer takes the result
//   sum       result modulo 2^WIDTH
//   cout      carry out of the MSB (subtract: 1 = no borrow)
//   overflow  two's-complement signed overflow
// ---------------------------------------------------------------------------
module multicycle_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int OFF_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;       // already inverted for subtract
    logic [WIDTH-1:0]   sum_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               cout_q;
    logic               ovf_q;

    // Chunk datapath: slice of the current chunk and its CHUNK+1 bit sum.
    logic [OFF_W-1:0]   off;
    logic [CHUNK-1:0]   ca;
    logic [CHUNK-1:0]   cb;
    logic [CHUNK:0]     cs;
    logic               msb_cin;

    // Signed overflow is the disagreement between the carry into and the
    // carry out of the sign bit.
    function automatic logic signed_overflow(input logic c_into_msb,
                                             input logic c_out_msb);
        return c_into_msb ^ c_out_msb;
    endfunction

    always_comb begin
        off     = OFF_W'(int'(idx_q) * CHUNK);
        ca      = a_q[off +: CHUNK];
        cb      = b_q[off +: CHUNK];
        cs      = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the top bit of this chunk, recovered from its sum bit.
        msb_cin = ca[CHUNK-1] ^ cb[CHUNK-1] ^ cs[CHUNK-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is a + ~b + 1; cin has no effect then.
                        a_q        <= a;
                        b_q        <= sub ? ~b : b;
                        carry_q    <= sub ? 1'b1 : cin;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    sum_q[off +: CHUNK] <= cs[CHUNK-1:0];
                    carry_q             <= cs[CHUNK];
                    if (idx_q == LAST_IDX) begin
                        cout_q      <= cs[CHUNK];
                        ovf_q       <= signed_overflow(msb_cin, cs[CHUNK]);
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    // Handshake edge only returns to IDLE; the next
                    // operation is taken on a later edge.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/multicycle_adder.md
MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, giving the bits added per cycle; WIDTH % CHUNK == 0 and CHUNK >= 1 are legal; N = WIDTH/CHUNK.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operands and mode present.
REQ-007 in_ready  output  1  block can accept an operation.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in, add mode only.
REQ-011 sub  input  1  0 = add (a+b+cin), 1 = subtract (a-b; cin ignored).
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer takes result.
REQ-014 sum  output  WIDTH  result modulo 2^WIDTH.
REQ-015 cout  output  1  carry out of MSB (subtract: 1 = no borrow).
REQ-016 overflow  output  1  two's-complement signed overflow.

Function
REQ-017 The FSM SHALL have states IDLE, CALC, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-018 Accept: in IDLE with in_valid=1 on a rising edge, the block SHALL latch a, b'=(sub ? ~b : b), c0=(sub ? 1 : cin), clear the chunk index, and go to CALC.
REQ-019 In CALC, each rising edge SHALL add chunk i of a and b' plus the stored carry, write it to bits [i*CHUNK +: CHUNK] of the sum register, store the chunk carry, and increment i (LSB chunk first).
REQ-020 After the edge processing chunk N-1, the FSM SHALL enter DONE; out_valid SHALL be visible exactly N cycles after the accept edge (N=1 when CHUNK=WIDTH).
REQ-021 cout SHALL equal the carry out of bit WIDTH-1; overflow SHALL equal carry-into-MSB XOR carry-out-of-MSB, both computed on the final chunk.
REQ-022 In DONE, sum/cout/overflow SHALL be stable while out_ready=0 (backpressure held indefinitely).
REQ-023 In DONE with out_ready=1 on a rising edge, the FSM SHALL return to IDLE; no new operation is accepted on that same edge.
REQ-024 in_valid, a, b, cin, sub SHALL be ignored outside IDLE; operand changes during CALC SHALL NOT affect the result.
REQ-025 out_ready SHALL be ignored outside DONE.
REQ-026 Outputs SHALL be driven from registers only; no combinational path from inputs to sum/cout/overflow.

Reset
REQ-027 rst_n=0 SHALL immediately, without a clock edge, force state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, overflow=0, chunk index 0, stored carry 0.
REQ-028 Reset asserted mid-CALC or in DONE SHALL abandon the operation; after release, the first result SHALL belong to the next accepted operation only.
REQ-029 After rst_n rises, the block SHALL accept an operation on the first rising edge with in_valid=1.

Verification (WIDTH=32, CHUNK=8, N=4)
REQ-030 a=0xFFFFFFFF, b=0x00000000, cin=1, sub=0 -> sum=0x00000000, cout=1, overflow=0, out_valid 4 cycles after accept.
REQ-031 a=0x7FFFFFFF, b=0x00000001, cin=0, sub=0 -> sum=0x80000000, cout=0, overflow=1.
REQ-032 a=5, b=7, sub=1, cin=1 -> sum=0xFFFFFFFE, cout=0, overflow=0 (cin ignored); a=7, b=5, sub=1 -> sum=2, cout=1.
REQ-033 Hold out_ready=0 for 10 cycles in DONE while changing a/b/in_valid -> outputs unchanged, in_ready=0; out_ready=1 -> IDLE next edge, then next op accepted.
REQ-034 Pulse rst_n=0 two cycles after accept -> out_valid=0, sum=0 at once; new op a=1, b=2 -> sum=3 with no stale result emitted.
REQ-035 Repeat REQ-030..031 with CHUNK=32 and CHUNK=1 -> identical results at latencies 1 and 32.
